// File: rtl/acc_sample_assembler_if.sv
// -----------------------------------------------------------------------------
// acc_sample_assembler_if
// Purpose : groups the byte-stream input and the axis-sample output of the
//           accelerometer sample assembler into one bundle.
// Signals : byte_valid/byte_data/frame_start/nack_err  - from the I2C read engine
//           ax/ay/az/sample_valid/frame_err/frame_cnt   - to flight control
// Modports: master - byte-stream producer / sample consumer side
//           slave  - the assembler itself
// -----------------------------------------------------------------------------
interface acc_sample_assembler_if;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               frame_start;
    logic               nack_err;
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic               sample_valid;
    logic               frame_err;
    logic [7:0]         frame_cnt;

    modport master (
        output byte_valid, byte_data, frame_start, nack_err,
        input  ax, ay, az, sample_valid, frame_err, frame_cnt
    );

    modport slave (
        input  byte_valid, byte_data, frame_start, nack_err,
        output ax, ay, az, sample_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/acc_sample_assembler.sv
// -----------------------------------------------------------------------------
// acc_sample_assembler
// Purpose : assembles the 6-byte burst (X_L X_H Y_L Y_H Z_L Z_H) from the
//           accelerometer I2C read engine into three signed 16-bit samples,
//           with resync / abort / inter-byte timeout framing checks.
// Ports   : clk12M - 12 MHz clock
//           rst    - synchronous active-high reset
//           bus    - acc_sample_assembler_if.slave (byte stream in, samples out)
// Params  : TIMEOUT_CYC - max cycles between consecutive bytes of one frame
//           LOW_FIRST   - 1: low byte of each axis first, 0: high byte first
// Option  : define ACC_AVG_EN to publish a 4-frame boxcar average per axis
//           (one extra cycle of latency, no strobe for the first 3 frames).
// -----------------------------------------------------------------------------
module acc_sample_assembler #(
    parameter int unsigned TIMEOUT_CYC = 4800,
    parameter bit          LOW_FIRST   = 1'b1
) (
    input  logic                  clk12M,
    input  logic                  rst,
    acc_sample_assembler_if.slave bus
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         buf_q [5];
    logic [7:0]         buf_d [5];
    logic signed [15:0] ax_q, ax_d;
    logic signed [15:0] ay_q, ay_d;
    logic signed [15:0] az_q, az_d;
    logic               sample_valid_q, sample_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic [15:0]        word_x, word_y, word_z;

    // Orders one axis byte pair into a 16-bit word.
    function automatic logic [15:0] pair_word(input logic [7:0] first, input logic [7:0] second);
        return LOW_FIRST ? {second, first} : {first, second};
    endfunction

    // The sixth byte is used straight off the bus so the word is ready on its arrival edge.
    assign word_x = pair_word(buf_q[0], buf_q[1]);
    assign word_y = pair_word(buf_q[2], buf_q[3]);
    assign word_z = pair_word(buf_q[4], bus.byte_data);

`ifdef ACC_AVG_EN
    logic signed [15:0] hist_q [3][4];
    logic signed [15:0] hist_d [3][4];
    logic [2:0]         fill_q, fill_d;

    // Mean of four samples, floor rounding (arithmetic shift of the 18-bit sum).
    function automatic logic signed [15:0] avg4(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c,
                                                input logic signed [15:0] d);
        logic signed [17:0] sum;
        sum = {{2{a[15]}}, a} + {{2{b[15]}}, b} + {{2{c[15]}}, c} + {{2{d[15]}}, d};
        return sum[17:2];
    endfunction
`endif

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        gap_d          = gap_q;
        buf_d          = buf_q;
        ax_d           = ax_q;
        ay_d           = ay_q;
        az_d           = az_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        frame_cnt_d    = frame_cnt_q;
`ifdef ACC_AVG_EN
        hist_d         = hist_q;
        fill_d         = fill_q;

        // Output stage of the filter runs in the PUBLISH cycle, on the updated history.
        if (state_q == ST_PUBLISH) begin
            ax_d           = avg4(hist_q[0][0], hist_q[0][1], hist_q[0][2], hist_q[0][3]);
            ay_d           = avg4(hist_q[1][0], hist_q[1][1], hist_q[1][2], hist_q[1][3]);
            az_d           = avg4(hist_q[2][0], hist_q[2][1], hist_q[2][2], hist_q[2][3]);
            sample_valid_d = (fill_q == 3'd4);
            frame_cnt_d    = frame_cnt_q + 8'd1;
        end
`endif

        case (state_q)
            // PUBLISH handles incoming bytes exactly like IDLE.
            ST_IDLE, ST_PUBLISH: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                gap_d   = '0;
                if (bus.byte_valid && !bus.nack_err) begin
                    if (bus.frame_start) begin
                        buf_d[0] = bus.byte_data;
                        idx_d    = 3'd1;
                        state_d  = ST_COLLECT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (bus.nack_err) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    idx_d       = 3'd0;
                    gap_d       = '0;
                end else if (bus.byte_valid && bus.frame_start) begin
                    // Resync: drop the partial frame, restart with this byte.
                    frame_err_d = 1'b1;
                    buf_d[0]    = bus.byte_data;
                    idx_d       = 3'd1;
                    gap_d       = '0;
                end else if (bus.byte_valid) begin
                    gap_d = '0;
                    if (idx_q == 3'd5) begin
                        state_d = ST_PUBLISH;
                        idx_d   = 3'd0;
`ifdef ACC_AVG_EN
                        for (int a = 0; a < 3; a++) begin
                            for (int k = 3; k > 0; k--) begin
                                hist_d[a][k] = hist_q[a][k-1];
                            end
                        end
                        hist_d[0][0] = word_x;
                        hist_d[1][0] = word_y;
                        hist_d[2][0] = word_z;
                        fill_d       = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
`else
                        ax_d           = word_x;
                        ay_d           = word_y;
                        az_d           = word_z;
                        sample_valid_d = 1'b1;
                        frame_cnt_d    = frame_cnt_q + 8'd1;
`endif
                    end else begin
                        buf_d[idx_q] = bus.byte_data;
                        idx_d        = idx_q + 3'd1;
                    end
                end else if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
                    // This idle cycle makes the gap TIMEOUT_CYC long: abort.
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    idx_d       = 3'd0;
                    gap_d       = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                gap_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk12M) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= 3'd0;
            gap_q          <= '0;
            for (int i = 0; i < 5; i++) begin
                buf_q[i] <= 8'd0;
            end
            ax_q           <= 16'sd0;
            ay_q           <= 16'sd0;
            az_q           <= 16'sd0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_cnt_q    <= 8'd0;
`ifdef ACC_AVG_EN
            for (int a = 0; a < 3; a++) begin
                for (int k = 0; k < 4; k++) begin
                    hist_q[a][k] <= 16'sd0;
                end
            end
            fill_q         <= 3'd0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            buf_q          <= buf_d;
            ax_q           <= ax_d;
            ay_q           <= ay_d;
            az_q           <= az_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            frame_cnt_q    <= frame_cnt_d;
`ifdef ACC_AVG_EN
            hist_q         <= hist_d;
            fill_q         <= fill_d;
`endif
        end
    end

    assign bus.ax           = ax_q;
    assign bus.ay           = ay_q;
    assign bus.az           = az_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule
